// File: rtl/led128_dec_pkg.sv
// led128_dec_pkg
//   Shared constants and FSM state type for LED-128 decryption controllers.
//   Round constants run backwards from RC_START (round 47) to RC_LAST (round 0).
package led128_dec_pkg;

  localparam int         STAGES_DEF    = 5;      // S-box pipeline depth (1..8)
  localparam logic [5:0] RC_START      = 6'h04;  // rc of round 47
  localparam logic [5:0] RC_LAST       = 6'h01;  // rc of round 0
  localparam int         NUM_ROUNDS    = 48;

  // One key addition every four rounds, counted down from the last step.
  localparam logic [1:0] PHASE_START   = 2'd3;
  localparam logic [3:0] KEYSTEP_START = 4'(NUM_ROUNDS / 4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINAL,
    ST_DONE
  } dec_state_e;

endpackage

// File: rtl/led_rc_lfsr_inv.sv
// led_rc_lfsr_inv
//   Combinational inverse of the LED round-constant LFSR.
//   Encryption steps rc -> {rc[4:0], rc[5] ~^ rc[4]}; this returns the
//   predecessor state so a decryptor can walk the constants backwards.
// Ports:
//   i_rc      : current 6-bit round constant
//   o_rc_prev : round constant of the preceding encryption round
module led_rc_lfsr_inv (
  input  logic [5:0] i_rc,
  output logic [5:0] o_rc_prev
);

  assign o_rc_prev = {i_rc[0] ~^ i_rc[5], i_rc[5:1]};

endmodule

// File: rtl/led128_dec_controller.sv
// led128_dec_controller
//   Sequencing FSM for an LED-128 decryption datapath. Walks rounds 47..0,
//   each held STAGES cycles, then one FINAL whitening cycle (state ^ K1) and a
//   one-cycle done pulse. Carries no key or state bits.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : launch a decryption (only looked at in IDLE)
//   rc_out          : round constant of the current inverse round
//   AddKey          : XOR the selected key into the state this round/step
//   SelKey          : 0 = K1, 1 = K2
//   RoundFunctionEN : inverse round datapath enable
//   busy            : RUN or FINAL
//   done            : one-cycle pulse, plaintext valid
module led128_dec_controller
  import led128_dec_pkg::*;
#(
  parameter int STAGES = STAGES_DEF   // legal range 1..8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] rc_out,
  output logic       AddKey,
  output logic       SelKey,
  output logic       RoundFunctionEN,
  output logic       busy,
  output logic       done
);

  dec_state_e        r_state;
  logic [5:0]        r_rc;
  logic [1:0]        r_phase;     // 3 on key-adding rounds, counts down per round
  logic [3:0]        r_keystep;   // parity picks K1/K2
  logic [STAGES-1:0] r_ring;      // one-hot position inside the current round

  logic [5:0]        w_rc_prev;
  logic              w_round_end;

  led_rc_lfsr_inv u_rc_inv (
    .i_rc      (r_rc),
    .o_rc_prev (w_rc_prev)
  );

  assign w_round_end = r_ring[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rc      <= RC_START;
      r_phase   <= PHASE_START;
      r_keystep <= KEYSTEP_START;
      r_ring    <= STAGES'(1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_ring <= w_round_end ? STAGES'(1) : (r_ring << 1);
          if (w_round_end) begin
            // Round 0 ends the loop; rc stays at RC_LAST through FINAL/DONE.
            if (r_rc == RC_LAST) begin
              r_state <= ST_FINAL;
            end else begin
              r_rc    <= w_rc_prev;
              r_phase <= r_phase - 2'd1;   // 2-bit wrap 0 -> 3
              if (r_phase == 2'd0) r_keystep <= r_keystep - 4'd1;
            end
          end
        end
        ST_FINAL: begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_rc      <= RC_START;
          r_phase   <= PHASE_START;
          r_keystep <= KEYSTEP_START;
          r_ring    <= STAGES'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pure decode of registered state: start never reaches an output.
  assign rc_out          = r_rc;
  assign RoundFunctionEN = (r_state == ST_RUN);
  assign busy            = (r_state == ST_RUN) || (r_state == ST_FINAL);
  assign done            = (r_state == ST_DONE);
  assign AddKey          = ((r_state == ST_RUN) && (r_phase == 2'd3)) || (r_state == ST_FINAL);
  assign SelKey          = (r_state == ST_RUN) && r_keystep[0];

endmodule
